sram_b_reader: RTL and testbench
================================

# sram_b_reader

Read sequencer between the `sram_B` weight buffer (1024 x 8, 1-cycle registered read, `ce`/`we`/`addr`/`din`/`dout`) and the systolic-array B-operand input. On `start` it walks a rows x cols tile at `base_addr` with a programmable row stride. It issues one SRAM read per cycle and absorbs the SRAM read latency in a small output FIFO. Tile elements leave as a valid/ready byte stream with row-end and tile-end markers.

## Interface
- `ADDR_W`, 10, SRAM address width; all address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, 8, element width; matches SRAM `dout`.
- `DIM_W`, 6, width of `rows`/`cols`; legal values 0..2^DIM_W-1.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  address of element (0,0); latched on accepted `start`.
- `row_stride`  in  ADDR_W  address distance between consecutive rows; latched on `start`.
- `rows`, `cols`  in  DIM_W  tile dimensions; latched on `start`.
- `busy`  out  1  high from accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse after last element handshaked.
- `sram_ce`  out  1  read enable to `sram_B.ce`.
- `sram_we`  out  1  tied 0.
- `sram_addr`  out  ADDR_W  to `sram_B.addr`.
- `sram_dout`  in  DATA_W  from `sram_B.dout`.
- `b_data`  out  DATA_W  stream data (FIFO head).
- `b_valid`  out  1  stream valid.
- `b_ready`  in  1  downstream ready; transfer when `b_valid && b_ready`.
- `b_last_row_elem`  out  1  head element is the last of its outer-loop line.
- `b_last`  out  1  head element is the final element of the tile.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`, latch the inputs, clear the element counters, and go to RUN. If `rows==0` or `cols==0`, go straight to DONE instead; no reads are issued. `start` outside IDLE is ignored.
- RUN: issue a read (`sram_ce=1`, `sram_addr`=current address) each cycle where `fifo_count + inflight < 4`.
  - `inflight` counts reads issued but not yet written into the FIFO, 0..2.
  - Inner counter `c` steps through 0..cols-1 with address +1.
  - At `c==cols-1`, row start address += `row_stride` and `c` returns to 0.
  - After the read of element (rows-1, cols-1) is issued, go to DRAIN.
- Data capture: a 2-stage shift of issue flags, each carrying the last-row-element and last-tile tags. When stage 2 is set, `sram_dout` is pushed into the 4-entry FIFO along with its tags.
- DRAIN: wait until `inflight==0` and the FIFO is empty (final element handshaked), then go to DONE.
- DONE: `done=1` for one cycle, then IDLE. `busy` stays 1 during DONE.
- Address arithmetic wraps modulo 2^ADDR_W; no error on wrap.
- The FIFO never overflows by construction; an overflow assertion belongs in the bench.
- Reset mid-operation: the FIFO, counters, and in-flight flags are cleared; data from a read already issued is discarded; state returns to IDLE. No `done` is produced.

## Timing
- Reset values: `busy=0`, `done=0`, `sram_ce=0`, `sram_we=0`, `sram_addr=0`, `b_valid=0`, `b_data=0`, `b_last_row_elem=0`, `b_last=0`.
- Let E0 be the edge that samples `start`:
  - first `sram_ce` is high in the cycle after E0;
  - SRAM output is registered at E1;
  - FIFO push occurs at E2;
  - `b_valid` is high after E2, so latency from `start` to first valid is 3 edges.
- With `b_ready` held at 1: one element per cycle, no bubbles. A tile of N elements completes its last handshake at edge E0+N+2. `done` is high in the following cycle.
- Backpressure: when `b_ready=0` the FIFO fills and issue stalls. `b_valid`/`b_data` hold steady until the handshake.
- Zero-size tile: `done` is high in the cycle after E0 (`busy` high that cycle too); `sram_ce` never asserts.

## Configuration
- `SRAM_B_RD_COL_MAJOR_EN`:
  - Defined: traversal is column-outer. The inner loop steps rows (address += `row_stride`); the outer loop steps columns (column base +1). `b_last_row_elem` marks the last element of each column.
  - Undefined: row-outer order as described in Operation.
  - Ports are identical in both builds.

## Test plan
- Reset values: assert `rst` 2 cycles, release -> every output at its reset value, state IDLE, `sram_ce=0`.
- Streaming: base 0x010, stride 4, rows 2, cols 3, `b_ready=1`, memory = address low byte -> `b_data` 10,11,12,14,15,16 on consecutive cycles. `b_last_row_elem` on the 3rd and 6th elements, `b_last` on the 6th, `done` one cycle later.
- Backpressure: same tile, `b_ready` toggled 1/0 each cycle -> same order with no loss or duplication, `sram_ce` stalls once FIFO plus in-flight reaches 4, `b_data` stable while stalled.
- Wrap and zero-size: base 0x3FE, stride 0, rows 1, cols 4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001. Then rows 0, cols 5 -> `done` the cycle after `start`, no `sram_ce`.
- Reset mid-op: assert `rst` while 2 reads are in flight and the FIFO holds 2 -> next cycle `b_valid=0`, IDLE, no `done`. A new `start` streams a correct tile.
- Build with `SRAM_B_RD_COL_MAJOR_EN`: base 0, stride 8, rows 2, cols 2 -> addresses 0, 8, 1, 9 and `b_last_row_elem` on the 2nd and 4th elements.

Source files
------------

// File: rtl/sram_b_reader.sv
// ---------------------------------------------------------------------------
// sram_b_reader
// Read sequencer between the sram_B weight buffer (1-cycle registered read)
// and the systolic-array B-operand input. On start it walks a rows x cols
// tile from base_addr with a programmable row stride and issues at most one
// SRAM read per cycle. A small 4-entry FIFO absorbs the SRAM read latency.
// Elements leave as a valid/ready byte stream tagged with line-end and
// tile-end markers.
//
// Build option:
//   SRAM_B_RD_COL_MAJOR_EN  defined   -> column-outer traversal (the inner
//                                        loop steps rows by row_stride)
//                           undefined -> row-outer traversal (default)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   base_addr         address of element (0,0)
//   row_stride        address distance between consecutive rows
//   rows, cols        tile dimensions (0 gives an empty tile)
//   busy, done        busy from accepted start through done; done is a pulse
//   sram_ce/we/addr   SRAM read port (we tied low)
//   sram_dout         SRAM read data, valid the cycle after ce
//   b_data/b_valid/b_ready              output stream handshake
//   b_last_row_elem   head element closes its outer-loop line
//   b_last            head element is the final element of the tile
// ---------------------------------------------------------------------------
module sram_b_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    output logic              busy,
    output logic              done,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic              b_last_row_elem,
    output logic              b_last
);

    localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
    localparam logic [DIM_W-1:0]  DIM_ZERO = DIM_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam int                ENTRY_W  = DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       inner_step_q, inner_step_d;
    logic [ADDR_W-1:0]       outer_step_q, outer_step_d;
    logic [DIM_W-1:0]        inner_max_q, inner_max_d;
    logic [DIM_W-1:0]        outer_max_q, outer_max_d;
    logic [DIM_W-1:0]        c_q, c_d;
    logic [DIM_W-1:0]        r_q, r_d;
    logic [ADDR_W-1:0]       next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]       line_base_q, line_base_d;
    // Issue stage: ce_q is the read presented to the SRAM this cycle.
    logic                    ce_q, ce_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    iss_row_q, iss_row_d;
    logic                    iss_last_q, iss_last_d;
    // Capture stage: sram_dout holds the data of this read.
    logic                    cap_q, cap_d;
    logic                    cap_row_q, cap_row_d;
    logic                    cap_last_q, cap_last_d;
    // Output FIFO, entry = {last, last_row_elem, data}.
    logic [3:0][ENTRY_W-1:0] fifo_q, fifo_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              count_q, count_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Combinational helpers.
    logic                    pop_s, push_s;
    logic [2:0]              count_next_s;
    logic [ADDR_W-1:0]       in_inner_step_s, in_outer_step_s;
    logic [DIM_W-1:0]        in_inner_max_s, in_outer_max_s;
    logic [ADDR_W-1:0]       src_addr_s, src_base_s, src_inner_step_s, src_outer_step_s;
    logic [DIM_W-1:0]        src_c_s, src_r_s, src_inner_max_s, src_outer_max_s;
    logic                    src_last_line_s, src_last_tile_s;
    logic                    want_issue_s, room_s, issue_s, empty_tile_s;
    logic [ENTRY_W-1:0]      head_s;

`ifdef SRAM_B_RD_COL_MAJOR_EN
    assign in_inner_step_s = row_stride;
    assign in_outer_step_s = ADDR_ONE;
    assign in_inner_max_s  = rows - DIM_ONE;
    assign in_outer_max_s  = cols - DIM_ONE;
`else
    assign in_inner_step_s = ADDR_ONE;
    assign in_outer_step_s = row_stride;
    assign in_inner_max_s  = cols - DIM_ONE;
    assign in_outer_max_s  = rows - DIM_ONE;
`endif

    // Next-state, address walk, issue throttling and FIFO bookkeeping.
    always_comb begin
        state_d      = state_q;
        inner_step_d = inner_step_q;
        outer_step_d = outer_step_q;
        inner_max_d  = inner_max_q;
        outer_max_d  = outer_max_q;
        c_d          = c_q;
        r_d          = r_q;
        next_addr_d  = next_addr_q;
        line_base_d  = line_base_q;
        ce_d         = 1'b0;
        addr_d       = addr_q;
        iss_row_d    = 1'b0;
        iss_last_d   = 1'b0;
        fifo_d       = fifo_q;

        empty_tile_s = (rows == DIM_ZERO) || (cols == DIM_ZERO);
        pop_s        = (count_q != 3'd0) && b_ready;
        push_s       = cap_q;
        count_next_s = count_q + {2'b00, push_s} - {2'b00, pop_s};

        // In IDLE the first read is issued straight from the ports so that
        // sram_ce rises in the cycle right after start is sampled.
        if (state_q == ST_IDLE) begin
            src_addr_s       = base_addr;
            src_base_s       = base_addr;
            src_c_s          = DIM_ZERO;
            src_r_s          = DIM_ZERO;
            src_inner_step_s = in_inner_step_s;
            src_outer_step_s = in_outer_step_s;
            src_inner_max_s  = in_inner_max_s;
            src_outer_max_s  = in_outer_max_s;
        end else begin
            src_addr_s       = next_addr_q;
            src_base_s       = line_base_q;
            src_c_s          = c_q;
            src_r_s          = r_q;
            src_inner_step_s = inner_step_q;
            src_outer_step_s = outer_step_q;
            src_inner_max_s  = inner_max_q;
            src_outer_max_s  = outer_max_q;
        end
        src_last_line_s = (src_c_s == src_inner_max_s);
        src_last_tile_s = src_last_line_s && (src_r_s == src_outer_max_s);

        case (state_q)
            ST_IDLE: want_issue_s = start && !empty_tile_s;
            ST_RUN:  want_issue_s = 1'b1;
            default: want_issue_s = 1'b0;
        endcase
        // The read decided now is presented next cycle; by then the reads in
        // flight are that read plus the one currently on the SRAM port, so
        // FIFO + in-flight never exceeds 4.
        room_s  = (count_next_s + {2'b00, ce_q}) < 3'd4;
        issue_s = want_issue_s && room_s;

        if (issue_s) begin
            ce_d       = 1'b1;
            addr_d     = src_addr_s;
            iss_row_d  = src_last_line_s;
            iss_last_d = src_last_tile_s;
            if (src_last_line_s) begin
                line_base_d = src_base_s + src_outer_step_s;
                next_addr_d = src_base_s + src_outer_step_s;
                c_d         = DIM_ZERO;
                r_d         = src_r_s + DIM_ONE;
            end else begin
                line_base_d = src_base_s;
                next_addr_d = src_addr_s + src_inner_step_s;
                c_d         = src_c_s + DIM_ONE;
                r_d         = src_r_s;
            end
        end else begin
            ce_d = 1'b0;
        end

        cap_d      = ce_q;
        cap_row_d  = iss_row_q;
        cap_last_d = iss_last_q;

        if (push_s) begin
            fifo_d[wr_ptr_q] = {cap_last_q, cap_row_q, sram_dout};
        end else begin
            fifo_d = fifo_q;
        end
        wr_ptr_d = wr_ptr_q + {1'b0, push_s};
        rd_ptr_d = rd_ptr_q + {1'b0, pop_s};
        count_d  = count_next_s;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    inner_step_d = in_inner_step_s;
                    outer_step_d = in_outer_step_s;
                    inner_max_d  = in_inner_max_s;
                    outer_max_d  = in_outer_max_s;
                    if (empty_tile_s) begin
                        state_d = ST_DONE;
                    end else if (issue_s && src_last_tile_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && src_last_tile_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge of the final handshake so done follows it
                // immediately.
                if ((count_next_s == 3'd0) && !ce_q && !cap_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inner_step_q <= {ADDR_W{1'b0}};
            outer_step_q <= {ADDR_W{1'b0}};
            inner_max_q  <= DIM_ZERO;
            outer_max_q  <= DIM_ZERO;
            c_q          <= DIM_ZERO;
            r_q          <= DIM_ZERO;
            next_addr_q  <= {ADDR_W{1'b0}};
            line_base_q  <= {ADDR_W{1'b0}};
            ce_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            iss_row_q    <= 1'b0;
            iss_last_q   <= 1'b0;
            cap_q        <= 1'b0;
            cap_row_q    <= 1'b0;
            cap_last_q   <= 1'b0;
            fifo_q       <= {(4*ENTRY_W){1'b0}};
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            inner_step_q <= inner_step_d;
            outer_step_q <= outer_step_d;
            inner_max_q  <= inner_max_d;
            outer_max_q  <= outer_max_d;
            c_q          <= c_d;
            r_q          <= r_d;
            next_addr_q  <= next_addr_d;
            line_base_q  <= line_base_d;
            ce_q         <= ce_d;
            addr_q       <= addr_d;
            iss_row_q    <= iss_row_d;
            iss_last_q   <= iss_last_d;
            cap_q        <= cap_d;
            cap_row_q    <= cap_row_d;
            cap_last_q   <= cap_last_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Stream outputs come from the FIFO head; zero when the FIFO is empty.
    always_comb begin
        head_s  = fifo_q[rd_ptr_q];
        b_valid = (count_q != 3'd0);
        if (b_valid) begin
            b_data          = head_s[DATA_W-1:0];
            b_last_row_elem = head_s[DATA_W];
            b_last          = head_s[DATA_W+1];
        end else begin
            b_data          = {DATA_W{1'b0}};
            b_last_row_elem = 1'b0;
            b_last          = 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_ce   = ce_q;
    assign sram_we   = 1'b0;
    assign sram_addr = addr_q;

endmodule

// File: tb/tb_sram_b_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_b_reader
// Directed bench for sram_b_reader. A behavioural sram_B returns the low
// byte of the address one cycle after ce. Tile vectors hold hand-computed
// read addresses and line/tile marker masks; hand-written sequences cover
// reset values and reset in the middle of a tile.
// ---------------------------------------------------------------------------
module tb_sram_b_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] base_addr = 10'h000;
    logic [9:0] row_stride = 10'h000;
    logic [5:0] rows = 6'd0;
    logic [5:0] cols = 6'd0;
    logic       busy, done, sram_ce, sram_we;
    logic [9:0] sram_addr;
    logic [7:0] sram_dout = 8'h00;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready = 1'b0;
    logic       b_last_row_elem, b_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural sram_B: registered read, contents = address low byte.
    always @(posedge clk) begin
        if (sram_ce) sram_dout <= sram_addr[7:0];
    end

    sram_b_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_stride(row_stride), .rows(rows), .cols(cols),
        .busy(busy), .done(done), .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .b_data(b_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_last_row_elem(b_last_row_elem), .b_last(b_last)
    );

    typedef struct packed {
        logic [9:0]      base;
        logic [9:0]      stride;
        logic [5:0]      rows;
        logic [5:0]      cols;
        logic            tog;     // 1: b_ready high only on odd cycles
        logic [3:0]      n;       // number of elements
        logic [7:0][9:0] addrs;   // expected read addresses, element 0 at [0]
        logic [7:0]      lr;      // expected b_last_row_elem per element
        logic [7:0]      last;    // expected b_last per element
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [9:0] base, input logic [9:0] stride,
                           input logic [5:0] r, input logic [5:0] c, input logic tog,
                           input logic [3:0] n, input logic [7:0][9:0] addrs,
                           input logic [7:0] lr, input logic [7:0] last);
        vecs[i].base   = base;
        vecs[i].stride = stride;
        vecs[i].rows   = r;
        vecs[i].cols   = c;
        vecs[i].tog    = tog;
        vecs[i].n      = n;
        vecs[i].addrs  = addrs;
        vecs[i].lr     = lr;
        vecs[i].last   = last;
    endtask

    task automatic run_vec(input int vi);
        vec_t       v;
        int         issued, popped, done_cyc, first_valid;
        logic       held_pend, saw_stall;
        logic [7:0] held;
        v = vecs[vi];
        issued = 0; popped = 0; done_cyc = -1; first_valid = -1;
        held_pend = 1'b0; saw_stall = 1'b0; held = 8'h00;
        @(negedge clk);
        base_addr  = v.base;
        row_stride = v.stride;
        rows       = v.rows;
        cols       = v.cols;
        b_ready    = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 200; cyc++) begin
            // A start pulse while busy must be ignored.
            if (v.tog && cyc == 1) begin
                start = 1'b1; base_addr = 10'h200; rows = 6'd0;
            end else begin
                start = 1'b0;
            end
            b_ready = v.tog ? (cyc % 2 == 1) : 1'b1;
            chk($sformatf("v%0d busy c%0d", vi, cyc), {31'd0, busy}, 32'd1);
            if (sram_ce) begin
                if (issued < int'(v.n)) begin
                    chk($sformatf("v%0d addr[%0d]", vi, issued), {22'd0, sram_addr},
                        {22'd0, v.addrs[issued]});
                end else begin
                    chk($sformatf("v%0d extra read", vi), {22'd0, sram_addr}, 32'hFFFF_FFFF);
                end
                issued++;
                chk($sformatf("v%0d occupancy<=4", vi), {31'd0, (issued - popped) <= 4}, 32'd1);
            end else if (issued > 0 && issued < int'(v.n)) begin
                saw_stall = 1'b1;
            end
            if (b_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (held_pend) chk($sformatf("v%0d hold data", vi), {24'd0, b_data}, {24'd0, held});
                if (b_ready) begin
                    if (popped < int'(v.n)) begin
                        chk($sformatf("v%0d data[%0d]", vi, popped), {24'd0, b_data},
                            {24'd0, v.addrs[popped][7:0]});
                        chk($sformatf("v%0d last_row[%0d]", vi, popped), {31'd0, b_last_row_elem},
                            {31'd0, v.lr[popped]});
                        chk($sformatf("v%0d last[%0d]", vi, popped), {31'd0, b_last},
                            {31'd0, v.last[popped]});
                    end else begin
                        chk($sformatf("v%0d extra element", vi), {24'd0, b_data}, 32'hFFFF_FFFF);
                    end
                    popped++;
                    held_pend = 1'b0;
                end else begin
                    held_pend = 1'b1;
                    held      = b_data;
                end
            end else begin
                if (held_pend) chk($sformatf("v%0d hold valid", vi), {31'd0, b_valid}, 32'd1);
                held_pend = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL v%0d timeout: actual no done required done within 200 cycles", vi);
        end
        chk($sformatf("v%0d issued", vi), issued, {28'd0, v.n});
        chk($sformatf("v%0d popped", vi), popped, {28'd0, v.n});
        if (!v.tog) begin
            chk($sformatf("v%0d done cycle", vi), done_cyc, (v.n == 4'd0) ? 0 : int'(v.n) + 2);
            if (v.n != 4'd0) chk($sformatf("v%0d first valid", vi), first_valid, 32'd2);
        end else begin
            chk($sformatf("v%0d issue stall", vi), {31'd0, saw_stall}, 32'd1);
        end
        @(negedge clk);
        chk($sformatf("v%0d done pulse end", vi), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d busy end", vi), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset values.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst sram_ce", {31'd0, sram_ce}, 32'd0);
        chk("rst sram_we", {31'd0, sram_we}, 32'd0);
        chk("rst sram_addr", {22'd0, sram_addr}, 32'd0);
        chk("rst b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst b_data", {24'd0, b_data}, 32'd0);
        chk("rst b_last_row_elem", {31'd0, b_last_row_elem}, 32'd0);
        chk("rst b_last", {31'd0, b_last}, 32'd0);

`ifdef SRAM_B_RD_COL_MAJOR_EN
        set_vec(0, 10'h010, 10'd4, 6'd2, 6'd3, 1'b0, 4'd6,
                {10'h0, 10'h0, 10'h016, 10'h012, 10'h015, 10'h011, 10'h014, 10'h010},
                8'b0010_1010, 8'b0010_0000);
        set_vec(1, 10'h010, 10'd4, 6'd2, 6'd3, 1'b1, 4'd6,
                {10'h0, 10'h0, 10'h016, 10'h012, 10'h015, 10'h011, 10'h014, 10'h010},
                8'b0010_1010, 8'b0010_0000);
        set_vec(2, 10'h3FE, 10'd0, 6'd1, 6'd4, 1'b0, 4'd4,
                {10'h0, 10'h0, 10'h0, 10'h0, 10'h001, 10'h000, 10'h3FF, 10'h3FE},
                8'b0000_1111, 8'b0000_1000);
        set_vec(3, 10'h000, 10'd8, 6'd2, 6'd2, 1'b0, 4'd4,
                {10'h0, 10'h0, 10'h0, 10'h0, 10'h009, 10'h001, 10'h008, 10'h000},
                8'b0000_1010, 8'b0000_1000);
`else
        set_vec(0, 10'h010, 10'd4, 6'd2, 6'd3, 1'b0, 4'd6,
                {10'h0, 10'h0, 10'h016, 10'h015, 10'h014, 10'h012, 10'h011, 10'h010},
                8'b0010_0100, 8'b0010_0000);
        set_vec(1, 10'h010, 10'd4, 6'd2, 6'd3, 1'b1, 4'd6,
                {10'h0, 10'h0, 10'h016, 10'h015, 10'h014, 10'h012, 10'h011, 10'h010},
                8'b0010_0100, 8'b0010_0000);
        set_vec(2, 10'h3FE, 10'd0, 6'd1, 6'd4, 1'b0, 4'd4,
                {10'h0, 10'h0, 10'h0, 10'h0, 10'h001, 10'h000, 10'h3FF, 10'h3FE},
                8'b0000_1000, 8'b0000_1000);
        set_vec(3, 10'h000, 10'd8, 6'd2, 6'd2, 1'b0, 4'd4,
                {10'h0, 10'h0, 10'h0, 10'h0, 10'h009, 10'h008, 10'h001, 10'h000},
                8'b0000_1010, 8'b0000_1000);
`endif
        set_vec(4, 10'h123, 10'd0, 6'd1, 6'd1, 1'b0, 4'd1,
                {10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h123},
                8'b0000_0001, 8'b0000_0001);
        set_vec(5, 10'h000, 10'd0, 6'd0, 6'd5, 1'b0, 4'd0,
                {10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0},
                8'b0000_0000, 8'b0000_0000);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset with two reads in flight and two elements in the FIFO.
        @(negedge clk);
        base_addr = 10'h010; row_stride = 10'd4; rows = 6'd2; cols = 6'd3;
        b_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst sram_ce before", {31'd0, sram_ce}, 32'd1);
        chk("midrst b_valid before", {31'd0, b_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst b_valid", {31'd0, b_valid}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst sram_ce", {31'd0, sram_ce}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("midrst idle done c%0d", k), {31'd0, done}, 32'd0);
            chk($sformatf("midrst idle valid c%0d", k), {31'd0, b_valid}, 32'd0);
        end
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
